result_uart_tx: RTL and testbench

- Serialises the 16-bit dot-product result and its overflow flag into ASCII and sends them on a UART TX line (8N1, LSB first).
- Faces the other way from the switch/debounce input path: operands arrive through switches, and results leave the board as a host-readable text line.
- Sits beside the MAC and the seven-segment display.
- Shares the top-level clock and the debounced reset.

---
 rtl/result_uart_tx.sv | 188 ++++++++++++++++++
 tb/tb_result_uart_tx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/result_uart_tx.sv
// rtl/result_uart_tx.sv - ASCII hex result/overflow line sender on an 8N1 UART
//
// Sends the 16-bit dot-product result as four uppercase hex digits (MSB nibble
// first), then a flag byte ('!' on overflow, ' ' otherwise). The frame format is
// 8N1, LSB first, with no gap between the bytes of one message.
// Optional feature: define RESULT_TX_CRLF_EN to append CR LF (7 bytes per message).
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - synchronous active-high reset
//   send   - transmit request; accepted only while busy=0
//   result - 16-bit value to report (snapshotted on acceptance)
//   oflow  - overflow flag to report (snapshotted on acceptance)
//   tx     - UART line, idles high (registered)
//   busy   - high while a message is in flight (registered)
//   done   - one-cycle pulse after the final stop bit (registered)
module result_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        send,
  input  logic [15:0] result,
  input  logic        oflow,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

`ifdef RESULT_TX_CRLF_EN
  localparam logic [2:0] LAST_BYTE = 3'd6;
`else
  localparam logic [2:0] LAST_BYTE = 3'd4;
`endif

  state_t            state, state_n;
  logic [BAUD_W-1:0] baud, baud_n;
  logic [2:0]        bit_idx, bit_n;
  logic [2:0]        byte_idx, byte_n;
  logic [7:0]        cur_byte, cur_n;
  logic [15:0]       res_q;
  logic              of_q;
  logic              accept;
  logic              baud_last;
  logic              tx_n, busy_n, done_n;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    // 'A' - 10 = 0x37
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [7:0] msg_byte(input logic [2:0] idx,
                                          input logic [15:0] r,
                                          input logic f);
    case (idx)
      3'd0:    return hex_ascii(r[15:12]);
      3'd1:    return hex_ascii(r[11:8]);
      3'd2:    return hex_ascii(r[7:4]);
      3'd3:    return hex_ascii(r[3:0]);
      3'd4:    return f ? 8'h21 : 8'h20;
`ifdef RESULT_TX_CRLF_EN
      3'd5:    return 8'h0D;
      3'd6:    return 8'h0A;
`endif
      default: return 8'h20;
    endcase
  endfunction

  // The DONE cycle reports busy=0, so a request there starts the next message
  // immediately and leaves exactly one idle-high cycle between frames.
  assign accept    = send && (state == S_IDLE || state == S_DONE);
  assign baud_last = (baud == BAUD_LAST);

  always_comb begin
    state_n = state;
    baud_n  = baud;
    bit_n   = bit_idx;
    byte_n  = byte_idx;
    cur_n   = cur_byte;
    case (state)
      S_IDLE, S_DONE: begin
        state_n = S_IDLE;
        if (accept) begin
          state_n = S_START;
          baud_n  = '0;
          bit_n   = 3'd0;
          byte_n  = 3'd0;
          cur_n   = msg_byte(3'd0, result, oflow);
        end
      end
      S_START: begin
        if (baud_last) begin
          baud_n  = '0;
          bit_n   = 3'd0;
          state_n = S_DATA;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = S_STOP;
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_n = '0;
          if (byte_idx == LAST_BYTE) begin
            state_n = S_DONE;
          end else begin
            byte_n  = byte_idx + 3'd1;
            cur_n   = msg_byte(byte_idx + 3'd1, res_q, of_q);
            state_n = S_START;
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered yet
    // change on the same edge as the state itself.
    tx_n   = 1'b1;
    busy_n = 1'b0;
    done_n = 1'b0;
    case (state_n)
      S_START: begin
        tx_n   = 1'b0;
        busy_n = 1'b1;
      end
      S_DATA: begin
        tx_n   = cur_n[bit_n];
        busy_n = 1'b1;
      end
      S_STOP:  busy_n = 1'b1;
      S_DONE:  done_n = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      baud     <= '0;
      bit_idx  <= 3'd0;
      byte_idx <= 3'd0;
      cur_byte <= 8'h00;
      res_q    <= 16'h0000;
      of_q     <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      baud     <= baud_n;
      bit_idx  <= bit_n;
      byte_idx <= byte_n;
      cur_byte <= cur_n;
      tx       <= tx_n;
      busy     <= busy_n;
      done     <= done_n;
      if (accept) begin
        res_q <= result;
        of_q  <= oflow;
      end
    end
  end

endmodule

// File: tb/tb_result_uart_tx.sv
// tb/tb_result_uart_tx.sv - scoreboard bench for result_uart_tx
module tb_result_uart_tx;
  localparam int CPB = 4;
`ifdef RESULT_TX_CRLF_EN
  localparam int NB = 7;
`else
  localparam int NB = 5;
`endif
  localparam int MSG_CYC = NB * 10 * CPB;

  logic        clk = 1'b0;
  logic        rst;
  logic        send;
  logic [15:0] result;
  logic        oflow;
  logic        tx;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  result_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk    (clk),
    .rst    (rst),
    .send   (send),
    .result (result),
    .oflow  (oflow),
    .tx     (tx),
    .busy   (busy),
    .done   (done)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] ascii_hex(input logic [3:0] n);
    string digits;
    digits = "0123456789ABCDEF";
    return digits[n];
  endfunction

  task automatic push_msg(input logic [15:0] r, input logic f);
    for (int i = 0; i < 4; i++) exp_q.push_back(ascii_hex(r[15-4*i -: 4]));
    exp_q.push_back(f ? 8'h21 : 8'h20);
`ifdef RESULT_TX_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endtask

  // Line monitor: decodes 8N1 frames at mid-bit and compares against the queue.
  bit         mon_active = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte = 8'h00;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      mon_active = 1'b0;
      exp_q.delete();
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % CPB == CPB / 2) begin
        if (mon_cnt / CPB == 0) begin
          check_eq("start_bit", tx, 1'b0);
        end else if (mon_cnt / CPB <= 8) begin
          mon_byte[mon_cnt/CPB-1] = tx;
        end else begin
          check_eq("stop_bit", tx, 1'b1);
          check_eq("rx_expected", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) check_eq("rx_byte", mon_byte, exp_q.pop_front());
          mon_active = 1'b0;
        end
      end
    end
  end

  task automatic start_msg(input logic [15:0] r, input logic f, input bit hold);
    result = r;
    oflow  = f;
    send   = 1'b1;
    push_msg(r, f);
    @(posedge clk);
    #1;
    check_eq("accept_tx", tx, 1'b0);
    check_eq("accept_busy", busy, 1'b1);
    if (!hold) send = 1'b0;
  endtask

  // Counts edges from acceptance until done; inject_at>0 pulses an ignored send.
  task automatic wait_done(input string tag, input int inject_at);
    int cyc;
    int busy_drops;
    cyc        = 0;
    busy_drops = 0;
    while (cyc < MSG_CYC + 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (inject_at > 0 && cyc == inject_at - 1) begin
        result = 16'h0000;
        oflow  = 1'b1;
        send   = 1'b1;
      end else if (inject_at > 0 && cyc == inject_at) begin
        send = 1'b0;
      end
      if (done) break;
      if (!busy) busy_drops++;
    end
    check_eq({tag, "_done_cycle"}, cyc, MSG_CYC);
    check_eq({tag, "_busy_held"}, busy_drops, 0);
    check_eq({tag, "_done_busy"}, busy, 1'b0);
    check_eq({tag, "_done_tx"}, tx, 1'b1);
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check_eq(tag, bad, 0);
  endtask

  initial begin
    rst    = 1'b1;
    send   = 1'b0;
    result = 16'h0000;
    oflow  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_tx", tx, 1'b1);
    check_eq("reset_busy", busy, 1'b0);
    check_eq("reset_done", done, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic message
    start_msg(16'h1A2F, 1'b0, 1'b0);
    wait_done("basic", 0);
    @(posedge clk);
    #1;
    check_eq("done_width", done, 1'b0);

    // Overflow flag and uppercase hex
    start_msg(16'hFFFF, 1'b1, 1'b0);
    wait_done("oflow", 0);
    @(posedge clk);
    #1;

    // Send while busy is ignored; snapshot protects the message in flight
    start_msg(16'h1A2F, 1'b0, 1'b0);
    wait_done("ignored", 37);
    watch_quiet("no_second_msg", 60);

    // Back-to-back with send held high
    start_msg(16'hBEEF, 1'b0, 1'b1);
    wait_done("b2b_first", 0);
    push_msg(16'hBEEF, 1'b0);
    @(posedge clk);
    #1;
    check_eq("b2b_restart_tx", tx, 1'b0);
    check_eq("b2b_restart_busy", busy, 1'b1);
    wait_done("b2b_second", 0);
    send = 1'b0;
    watch_quiet("b2b_stop", 20);

    // Reset mid-frame at k+90
    start_msg(16'h5A5A, 1'b1, 1'b0);
    repeat (89) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_tx", tx, 1'b1);
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_done", done, 1'b0);
    watch_quiet("midrst_hold", 5);
    rst = 1'b0;
    watch_quiet("midrst_after", 10);
    start_msg(16'h0009, 1'b0, 1'b0);
    wait_done("after_rst", 0);
    @(posedge clk);
    #1;

    // send and rst at the same edge: reset wins
    rst  = 1'b1;
    send = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_send_tx", tx, 1'b1);
    check_eq("rst_send_busy", busy, 1'b0);
    rst  = 1'b0;
    send = 1'b0;
    watch_quiet("rst_send_quiet", 50);

    check_eq("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
